// File: rtl/soc_system_settings_bank_if.sv
// Avalon-MM slave bus bundle for the settings register bank.
// The HPS side drives the master modport; the bank uses the slave modport.
interface soc_system_settings_bank_if #(
    parameter int unsigned ADDR_W = 3
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_settings_bank.sv
// Shadow/active settings bank: the HPS writes saturated shadow values, and a commit
// copies all of them to the active outputs atomically once the consumer allows it.
module soc_system_settings_bank #(
    parameter int unsigned     NUM_CH    = 4,
    parameter int unsigned     DATA_W    = 12,
    parameter int unsigned     ADDR_W    = 3,
    parameter longint unsigned MAX_VAL   = (64'd1 << DATA_W) - 64'd1,
    parameter longint unsigned RESET_VAL = 64'd0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    soc_system_settings_bank_if.slave  bus,
    input  logic                       apply_en,
    output logic [NUM_CH*DATA_W-1:0]   out_port,
    output logic [NUM_CH-1:0]          update_strobe,
    output logic                       commit_pending
);
    localparam logic [DATA_W-1:0] MAX_V     = DATA_W'(MAX_VAL);
    localparam logic [DATA_W-1:0] RST_V     = DATA_W'(RESET_VAL);
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NUM_CH + 1);
    localparam logic [NUM_CH-1:0] CH_ZERO   = {NUM_CH{1'b0}};

    logic [DATA_W-1:0] shadow_q [NUM_CH];
    logic [DATA_W-1:0] shadow_d [NUM_CH];
    logic [DATA_W-1:0] active_q [NUM_CH];
    logic [DATA_W-1:0] active_d [NUM_CH];
    logic [NUM_CH-1:0] dirty_q, dirty_d;
    logic [NUM_CH-1:0] strobe_q, strobe_d;
    logic              pending_q, pending_d;
    logic              lock_q, lock_d;
    logic              drop_q, drop_d;
    logic              clip_q, clip_d;

    logic              wr_s;
    logic              ctrl_wr_s;
    logic              stat_wr_s;
    logic              blocked_s;
    logic              apply_s;
    logic              over_s;
    logic [DATA_W-1:0] wval_s;
    logic [DATA_W-1:0] clipped_s;
    logic [NUM_CH-1:0] shadow_hit_s;
    logic              any_shadow_s;
    logic [31:0]       readdata_s;
    logic              unused_wdata_s;

    // Bus write decode and saturation of the incoming value.
    always_comb begin
        wr_s      = bus.chipselect && !bus.write_n;
        ctrl_wr_s = wr_s && (bus.address == CTRL_ADDR);
        stat_wr_s = wr_s && (bus.address == STAT_ADDR);
        blocked_s = lock_q || pending_q;
        apply_s   = pending_q && apply_en;
        wval_s    = bus.writedata[DATA_W-1:0];
        over_s    = (wval_s > MAX_V);
        clipped_s = over_s ? MAX_V : wval_s;
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_hit_s[i] = wr_s && (bus.address == ADDR_W'(i));
        end
        any_shadow_s = |shadow_hit_s;
    end

    // Next-state: shadow writes are blocked while locked or a commit is waiting,
    // so they can never collide with the apply that clears dirty.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = (shadow_hit_s[i] && !blocked_s) ? clipped_s : shadow_q[i];
            active_d[i] = apply_s ? shadow_q[i] : active_q[i];
        end
        dirty_d   = (apply_s ? CH_ZERO : dirty_q) | (blocked_s ? CH_ZERO : shadow_hit_s);
        strobe_d  = apply_s ? dirty_q : CH_ZERO;
        pending_d = apply_s ? 1'b0 : (pending_q || (ctrl_wr_s && bus.writedata[0]));
        lock_d    = ctrl_wr_s ? bus.writedata[1] : lock_q;
        drop_d    = (stat_wr_s && bus.writedata[30]) ? 1'b0
                  : (drop_q || (any_shadow_s && blocked_s));
        clip_d    = (stat_wr_s && bus.writedata[31]) ? 1'b0
                  : (clip_q || (any_shadow_s && !blocked_s && over_s));
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= RST_V;
                active_q[i] <= RST_V;
            end
            dirty_q   <= CH_ZERO;
            strobe_q  <= CH_ZERO;
            pending_q <= 1'b0;
            lock_q    <= 1'b0;
            drop_q    <= 1'b0;
            clip_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
            dirty_q   <= dirty_d;
            strobe_q  <= strobe_d;
            pending_q <= pending_d;
            lock_q    <= lock_d;
            drop_q    <= drop_d;
            clip_q    <= clip_d;
        end
    end

    // Zero-wait-state read mux; unmapped addresses fall through to zero.
    always_comb begin
        readdata_s = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            readdata_s = (bus.address == ADDR_W'(i)) ? 32'(shadow_q[i]) : readdata_s;
        end
        readdata_s = (bus.address == CTRL_ADDR) ? {30'd0, lock_q, pending_q} : readdata_s;
        readdata_s = (bus.address == STAT_ADDR) ? {clip_q, drop_q, 30'(dirty_q)} : readdata_s;
    end

    assign bus.readdata   = readdata_s;
    assign update_strobe  = strobe_q;
    assign commit_pending = pending_q;
    assign unused_wdata_s = ^bus.writedata;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_port[g*DATA_W +: DATA_W] = active_q[g];
    end
endmodule

// File: tb/tb_soc_system_settings_bank.sv
// Directed bench for soc_system_settings_bank (4 channels, 12-bit, ceiling 3000);
// expectations are queued with each stimulus step and popped when the DUT answers.
module tb_soc_system_settings_bank;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned ADDR_W = 3;

    logic                     clk;
    logic                     reset_n;
    logic                     apply_en;
    logic [NUM_CH*DATA_W-1:0] out_port;
    logic [NUM_CH-1:0]        update_strobe;
    logic                     commit_pending;

    soc_system_settings_bank_if #(.ADDR_W(ADDR_W)) bus_if ();

    soc_system_settings_bank #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_VAL  (64'd3000),
        .RESET_VAL(64'd0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus_if),
        .apply_en      (apply_en),
        .out_port      (out_port),
        .update_strobe (update_strobe),
        .commit_pending(commit_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] pk(input int c0, input int c1, input int c2, input int c3);
        return {16'd0, 12'(c3), 12'(c2), 12'(c1), 12'(c0)};
    endfunction

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // One write transfer: presented after a falling edge, taken on the next rising edge.
    task automatic wr(input int addr, input logic [31:0] data);
        @(negedge clk);
        bus_if.address    = ADDR_W'(addr);
        bus_if.writedata  = data;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'd0;
    endtask

    task automatic rd_check(input string tag, input int addr, input logic [31:0] exp);
        push(tag, {32'd0, exp});
        bus_if.address    = ADDR_W'(addr);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        #1;
        pop_check({32'd0, bus_if.readdata});
        bus_if.chipselect = 1'b0;
    endtask

    task automatic out_check(input string tag, input logic [63:0] exp_out,
                             input logic [3:0] exp_stb, input logic exp_pend);
        push({tag, "_out"}, exp_out);
        push({tag, "_stb"}, {60'd0, exp_stb});
        push({tag, "_pend"}, {63'd0, exp_pend});
        pop_check({16'd0, out_port});
        pop_check({60'd0, update_strobe});
        pop_check({63'd0, commit_pending});
    endtask

    initial begin
        reset_n           = 1'b0;
        apply_en          = 1'b0;
        bus_if.address    = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        for (int a = 0; a < 8; a++) rd_check($sformatf("reset_rd%0d", a), a, 32'd0);
        out_check("reset", 64'd0, 4'b0000, 1'b0);

        // Saturation: low 12 bits of 0x1F40 are 0xF40 = 3904 > 3000
        wr(0, 32'h0000_1F40);
        rd_check("clip_rd_ch0", 0, 32'd3000);
        rd_check("clip_status", 5, 32'h8000_0001);
        wr(5, 32'h8000_0000);
        rd_check("clip_cleared", 5, 32'h0000_0001);

        // Commit with apply_en already high: apply lands one edge after the commit write
        apply_en = 1'b1;
        wr(4, 32'd1);
        out_check("same_edge_commit", 64'd0, 4'b0000, 1'b1);
        @(negedge clk);
        out_check("same_edge_apply", pk(3000, 0, 0, 0), 4'b0001, 1'b0);
        apply_en = 1'b0;
        @(negedge clk);
        out_check("same_edge_after", pk(3000, 0, 0, 0), 4'b0000, 1'b0);

        // Held commit, drop while pending, ignored second commit
        wr(1, 32'd100);
        wr(3, 32'd200);
        rd_check("dirty_mask", 5, 32'h0000_000A);
        wr(4, 32'd1);
        repeat (5) @(negedge clk);
        out_check("held", pk(3000, 0, 0, 0), 4'b0000, 1'b1);
        rd_check("ctrl_pending", 4, 32'h0000_0001);
        wr(2, 32'd55);
        rd_check("drop_ch2", 2, 32'd0);
        rd_check("drop_status", 5, 32'h4000_000A);
        wr(4, 32'd1);
        apply_en = 1'b1;
        @(negedge clk);
        apply_en = 1'b0;
        out_check("apply", pk(3000, 100, 0, 200), 4'b1010, 1'b0);
        @(negedge clk);
        out_check("apply_after", pk(3000, 100, 0, 200), 4'b0000, 1'b0);
        rd_check("apply_status", 5, 32'h4000_0000);
        wr(5, 32'h4000_0000);
        rd_check("drop_cleared", 5, 32'h0000_0000);

        // Locked shadow write is dropped
        wr(4, 32'd2);
        rd_check("ctrl_lock", 4, 32'h0000_0002);
        wr(2, 32'd77);
        rd_check("lock_ch2", 2, 32'd0);
        rd_check("lock_status", 5, 32'h4000_0000);
        wr(4, 32'd0);
        wr(5, 32'h4000_0000);

        // Exact ceiling is not a clip; upper writedata bits ignored; unmapped write inert
        wr(2, 32'd3000);
        rd_check("ceiling_ch2", 2, 32'd3000);
        rd_check("ceiling_status", 5, 32'h0000_0004);
        wr(1, 32'hABC0_0005);
        rd_check("upper_bits_ch1", 1, 32'd5);
        wr(7, 32'hFFFF_FFFF);
        rd_check("unmapped_rd", 7, 32'd0);
        rd_check("unmapped_status", 5, 32'h0000_0006);

        // Asynchronous reset while a commit is pending with dirty = 0110
        wr(4, 32'd1);
        out_check("pre_reset", pk(3000, 100, 0, 200), 4'b0000, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        out_check("async_reset", 64'd0, 4'b0000, 1'b0);
        rd_check("reset_status", 5, 32'd0);
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        apply_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_check($sformatf("post_reset%0d", k), 64'd0, 4'b0000, 1'b0);
        end
        rd_check("post_reset_ch1", 1, 32'd0);
        rd_check("post_reset_ctrl", 4, 32'd0);
        apply_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
